// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: default address/data widths (also used by the decoder and the
//           datapath), the FSM state encoding, the word-alignment mask and
//           an alignment helper function.
package mem_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   // Byte-offset bits that must be zero for a word access.
   localparam logic [1:0] WORD_OFS_MASK = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   // True when the two low address bits describe a word-aligned address.
   function automatic logic word_aligned(input logic [1:0] lsb);
      return ((lsb & WORD_OFS_MASK) == 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access unit and the memory.
// master : memory-access unit (drives memreq, memwe, memaddr, memwdata;
//          receives memready, memrdata).
// slave  : data memory / bus fabric (opposite directions).
interface mem_access_unit_if #(
   parameter int AW = mem_pkg::AW_DEF,
   parameter int DW = mem_pkg::DW_DEF
);

   logic          memreq;
   logic          memwe;
   logic [AW-1:0] memaddr;
   logic [DW-1:0] memwdata;
   logic          memready;
   logic [DW-1:0] memrdata;

   modport master (
      output memreq, memwe, memaddr, memwdata,
      input  memready, memrdata
   );

   modport slave (
      input  memreq, memwe, memaddr, memwdata,
      output memready, memrdata
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Bus-wait timeout counter.
// Ports: clock, reset_n (async, active-low); clr restarts the count at 0;
//        en advances it by one; tc flags that the count has reached
//        TIMEOUT-1. tc is held at 0 when TIMEOUT is 0 (timeout disabled).
module mem_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [CW-1:0] cnt_r;

   // Count register: clear has priority over enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tc = (TIMEOUT != 0) && (cnt_r == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access unit: turns the MEM-stage readmem/writemem strobes into a
// request/ready transaction on a variable-latency data-memory bus, stalls
// the pipeline while the access is outstanding and returns load data.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   readmem, writemem   load / store request (writemem wins if both set)
//   addr, wdata         byte address and store data from the pipeline
//   stall               combinational pipeline hold
//   rdata, rvalid       registered load result and its one-cycle strobe
//   misalign, buserr    one-cycle error pulses (unaligned request, timeout)
//   bus                 data-memory bus, master side
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              readmem,
   input  logic              writemem,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     wdata,
   output logic              stall,
   output logic [DW-1:0]     rdata,
   output logic              rvalid,
   output logic              misalign,
   output logic              buserr,
   mem_access_unit_if.master bus
);

   state_e        state_r, state_nx_s;
   logic          memreq_r, memreq_nx_s;
   logic          memwe_r, memwe_nx_s;
   logic [AW-1:0] memaddr_r, memaddr_nx_s;
   logic [DW-1:0] memwdata_r, memwdata_nx_s;
   logic [DW-1:0] rdata_r, rdata_nx_s;
   logic          rvalid_r, rvalid_nx_s;
   logic          misalign_r, misalign_nx_s;
   logic          buserr_r, buserr_nx_s;
   logic          req_s, aligned_s;
   logic          ctr_clr_s, ctr_en_s, tc_s;
   logic          stall_s;

   assign req_s     = readmem | writemem;
   assign aligned_s = word_aligned(addr[1:0]);

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (ctr_clr_s),
      .en      (ctr_en_s),
      .tc      (tc_s)
   );

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and next-value logic for the bus, result and pulse registers.
   always_comb begin
      state_nx_s    = state_r;
      memreq_nx_s   = memreq_r;
      memwe_nx_s    = memwe_r;
      memaddr_nx_s  = memaddr_r;
      memwdata_nx_s = memwdata_r;
      rdata_nx_s    = rdata_r;
      rvalid_nx_s   = 1'b0;
      misalign_nx_s = 1'b0;
      buserr_nx_s   = 1'b0;
      ctr_clr_s     = 1'b0;
      ctr_en_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_s && aligned_s) begin
               memaddr_nx_s  = {addr[AW-1:2], 2'b00};
               memwdata_nx_s = wdata;
               memwe_nx_s    = writemem;   // a simultaneous read+write is a store
               memreq_nx_s   = 1'b1;
               ctr_clr_s     = 1'b1;
               state_nx_s    = S_ACCESS;
            end else if (req_s) begin
               misalign_nx_s = 1'b1;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_ACCESS: begin
            // memready is checked first so a completion on the terminal
            // cycle is never reported as a timeout.
            if (bus.memready) begin
               memreq_nx_s = 1'b0;
               memwe_nx_s  = 1'b0;
               state_nx_s  = S_DONE;
               if (!memwe_r) begin
                  rdata_nx_s  = bus.memrdata;
                  rvalid_nx_s = 1'b1;
               end else begin
                  rdata_nx_s = rdata_r;
               end
            end else if (tc_s) begin
               memreq_nx_s = 1'b0;
               memwe_nx_s  = 1'b0;
               buserr_nx_s = 1'b1;
               state_nx_s  = S_DONE;
            end else begin
               ctr_en_s = 1'b1;
            end
         end
         S_DONE: begin
            state_nx_s = S_IDLE;
         end
         default: begin
            state_nx_s  = S_IDLE;
            memreq_nx_s = 1'b0;
            memwe_nx_s  = 1'b0;
         end
      endcase
   end

   // Bus, result and pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         memreq_r   <= 1'b0;
         memwe_r    <= 1'b0;
         memaddr_r  <= {AW{1'b0}};
         memwdata_r <= {DW{1'b0}};
         rdata_r    <= {DW{1'b0}};
         rvalid_r   <= 1'b0;
         misalign_r <= 1'b0;
         buserr_r   <= 1'b0;
      end else begin
         memreq_r   <= memreq_nx_s;
         memwe_r    <= memwe_nx_s;
         memaddr_r  <= memaddr_nx_s;
         memwdata_r <= memwdata_nx_s;
         rdata_r    <= rdata_nx_s;
         rvalid_r   <= rvalid_nx_s;
         misalign_r <= misalign_nx_s;
         buserr_r   <= buserr_nx_s;
      end
   end

   // Pipeline hold: an aligned request must stall in IDLE so the pipeline
   // waits for the access it has just launched.
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_s && aligned_s) begin
               stall_s = 1'b1;
            end else begin
               stall_s = 1'b0;
            end
         end
         S_ACCESS: stall_s = 1'b1;
         S_DONE:   stall_s = 1'b0;
         default:  stall_s = 1'b0;
      endcase
   end

   assign stall        = stall_s;
   assign rdata        = rdata_r;
   assign rvalid       = rvalid_r;
   assign misalign     = misalign_r;
   assign buserr       = buserr_r;
   assign bus.memreq   = memreq_r;
   assign bus.memwe    = memwe_r;
   assign bus.memaddr  = memaddr_r;
   assign bus.memwdata = memwdata_r;

endmodule
